load_store_unit: RTL and testbench

- Initiator side of the byte-wide data-memory interface used by the MIPS32 datapath.
- Accepts one load/store request from the core and splits it into byte-serial accesses: 1, 2 or 4 beats, big-endian, lowest address = most significant byte.
- On loads, reassembles the bytes and sign- or zero-extends them into a 32-bit result for the register file.
- Sits between the MEM stage and the byte-addressed data memory.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/load_extend.sv | 34 +++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-type encodings, the
// sequencer state type and small decode helpers used by the sequencer and the
// load extension logic.
// -----------------------------------------------------------------------------
package lsu_pkg;

   // Access-type encodings as presented on the core's op bus.
   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_SW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   // Number of byte beats needed for an access type.
   function automatic logic [2:0] beat_count(input logic [2:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 3'd1;
         OP_LH, OP_LHU, OP_SH: return 3'd2;
         default:              return 3'd4;
      endcase
   endfunction

   function automatic logic is_store(input logic [2:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_unsigned(input logic [2:0] op);
      return (op == OP_LBU) || (op == OP_LHU);
   endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of the bytes gathered for a load.
//   assembled : loaded bytes, right-justified (last beat in bits [7:0])
//   op        : access type of the load
//   result    : value handed to the register file
// -----------------------------------------------------------------------------
module load_extend
   import lsu_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic [SIZE-1:0] assembled,
   input  logic [2:0]      op,
   output logic [SIZE-1:0] result
);

   logic fill_b;
   logic fill_h;

   // Unsigned loads fill with zeros regardless of the top data bit.
   assign fill_b = !is_unsigned(op) && assembled[7];
   assign fill_h = !is_unsigned(op) && assembled[15];

   always_comb begin
      result = assembled;
      case (op)
         OP_LB, OP_LBU: result = {{(SIZE-8){fill_b}}, assembled[7:0]};
         OP_LH, OP_LHU: result = {{(SIZE-16){fill_h}}, assembled[15:0]};
         default:       result = assembled;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Splits one core load/store into 1, 2 or 4 big-endian byte beats on the data
// memory bus and reassembles/extends load data.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req, op, addr,
//   wdata             : core request, sampled only while idle
//   busy, done, err,
//   rdata             : core status and load result (valid with done)
//   mem_addr, mem_wdata,
//   mem_we, mem_re    : registered beat presented to memory
//   mem_rdata,
//   mem_ready         : memory response; a beat completes when mem_ready=1
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int          SIZE          = 32,
   parameter logic [31:0] MEM_BYTES     = 32'h7FF,
   parameter int          SIZE_WORD_MEM = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic [2:0]               op,
   input  logic [SIZE-1:0]          addr,
   input  logic [SIZE-1:0]          wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [SIZE-1:0]          rdata,
   output logic [SIZE-1:0]          mem_addr,
   output logic [SIZE_WORD_MEM-1:0] mem_wdata,
   output logic                     mem_we,
   output logic                     mem_re,
   input  logic [SIZE_WORD_MEM-1:0] mem_rdata,
   input  logic                     mem_ready
);

   state_e          state;
   logic [1:0]      k_q;
   logic [2:0]      op_q;
   logic [2:0]      n_q;
   logic [SIZE-1:0] wsh_q;
   logic [SIZE-1:0] asm_q;

   logic [2:0]      n_req;
   logic [SIZE:0]   last_addr;
   logic            bad_req;
   logic [SIZE-1:0] walign;
   logic [SIZE-1:0] asm_next;
   logic [SIZE-1:0] ext;
   logic            beat_done;
   logic            last_beat;

   assign n_req = beat_count(op);

   // Range check is done one bit wider so an address near the top of the
   // 32-bit space cannot wrap around into the valid range.
   assign last_addr = {1'b0, addr} + (SIZE+1)'(n_req) - (SIZE+1)'(1);
   assign bad_req   = ((n_req == 3'd2) && addr[0]) ||
                      ((n_req == 3'd4) && (addr[1:0] != 2'b00)) ||
                      (last_addr >= (SIZE+1)'(MEM_BYTES));

   // Left-justify store data so the first beat always comes from the top byte.
   always_comb begin
      case (n_req)
         3'd1:    walign = wdata << (SIZE - 8);
         3'd2:    walign = wdata << (SIZE - 16);
         default: walign = wdata;
      endcase
   end

   assign asm_next  = (asm_q << SIZE_WORD_MEM) | SIZE'(mem_rdata);
   assign beat_done = mem_ready && (mem_we || mem_re);
   assign last_beat = ({1'b0, k_q} == (n_q - 3'd1));

   load_extend #(.SIZE(SIZE)) u_ext (
      .assembled(asm_next),
      .op       (op_q),
      .result   (ext)
   );

   // Request/shift datapath: no reset needed, always loaded before use.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && req) begin
         op_q  <= op;
         n_q   <= n_req;
         wsh_q <= walign << SIZE_WORD_MEM;
         asm_q <= '0;
      end else if (state == ST_ACCESS && beat_done) begin
         asm_q <= asm_next;
         wsh_q <= wsh_q << SIZE_WORD_MEM;
      end
   end

   // Sequencer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         k_q       <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (req) begin
                  busy <= 1'b1;
                  k_q  <= 2'd0;
                  if (bad_req) begin
                     // Rejected requests never touch the memory bus.
                     state <= ST_FINISH;
                     done  <= 1'b1;
                     err   <= 1'b1;
                     if (!is_store(op)) rdata <= '0;
                  end else begin
                     state     <= ST_ACCESS;
                     mem_addr  <= addr;
                     mem_wdata <= walign[SIZE-1 -: SIZE_WORD_MEM];
                     mem_we    <= is_store(op);
                     mem_re    <= !is_store(op);
                  end
               end
            end
            ST_ACCESS: begin
               if (beat_done) begin
                  k_q <= k_q + 2'd1;
                  if (last_beat) begin
                     state     <= ST_FINISH;
                     done      <= 1'b1;
                     mem_we    <= 1'b0;
                     mem_re    <= 1'b0;
                     mem_addr  <= '0;
                     mem_wdata <= '0;
                     if (!is_store(op_q)) rdata <= ext;
                  end else begin
                     mem_addr  <= mem_addr + SIZE'(1);
                     mem_wdata <= wsh_q[SIZE-1 -: SIZE_WORD_MEM];
                  end
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: a byte memory behind the DUT, a
// reference model of the access rules, a vector table, hand-written sequences
// for stalls / held requests / mid-access reset, and a randomized phase.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam logic [2:0] L_LB  = 3'b000;
   localparam logic [2:0] L_LH  = 3'b001;
   localparam logic [2:0] L_LW  = 3'b010;
   localparam logic [2:0] L_SW  = 3'b011;
   localparam logic [2:0] L_LBU = 3'b100;
   localparam logic [2:0] L_LHU = 3'b101;
   localparam logic [2:0] L_SB  = 3'b110;
   localparam logic [2:0] L_SH  = 3'b111;
   localparam longint unsigned MEMB = 64'h7FF;

   typedef struct {
      logic [31:0] a;
      logic        we;
      logic [7:0]  d;
   } beat_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic [2:0]  op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy, done, err;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we, mem_re;
   logic [7:0]  mem_rdata;
   logic        mem_ready;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // ---------------- memory and bus monitor ----------------
   logic [7:0] mem [2048] = '{default: 8'h00};
   beat_t      beat_log[$];
   int         strobe_total = 0;
   int         stall_total  = 0;
   int         both_total   = 0;
   int         done_cnt     = 0;

   assign mem_rdata = mem[mem_addr[10:0]];

   always @(posedge clk) begin
      beat_t bt;
      if (mem_we || mem_re) strobe_total <= strobe_total + 1;
      if ((mem_we || mem_re) && !mem_ready) stall_total <= stall_total + 1;
      if (mem_we && mem_re) both_total <= both_total + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mem_ready && (mem_we || mem_re)) begin
         bt.a  = mem_addr;
         bt.we = mem_we;
         bt.d  = mem_wdata;
         beat_log.push_back(bt);
         if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;
      end
   end

   // mem_ready: 0 = always ready, 1 = random, 2 = stall a chosen address
   int          rdy_mode   = 0;
   logic [31:0] stall_at   = 32'h0;
   int          stall_len  = 0;
   int          stall_used = 0;

   always @(negedge clk) begin
      if (rdy_mode == 1)
         mem_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 2 && (mem_we || mem_re) && mem_addr == stall_at && stall_used < stall_len) begin
         mem_ready  = 1'b0;
         stall_used = stall_used + 1;
      end else
         mem_ready = 1'b1;
      if (rdy_mode != 2) stall_used = 0;
   end

   // ---------------- reference model ----------------
   logic [7:0]  ref_mem [2048];
   beat_t       exp_beats[$];
   logic        m_err;
   logic [31:0] m_rdata = 32'h0;
   int          m_n;

   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
      int n; bit st; bit sg;
      longint unsigned v, last;
      longint sv;
      beat_t bt;
      n = 4; st = 1; sg = 0;
      case (o)
         L_LB:  begin n = 1; st = 0; sg = 1; end
         L_LBU: begin n = 1; st = 0; sg = 0; end
         L_LH:  begin n = 2; st = 0; sg = 1; end
         L_LHU: begin n = 2; st = 0; sg = 0; end
         L_LW:  begin n = 4; st = 0; sg = 0; end
         L_SB:  begin n = 1; st = 1; end
         L_SH:  begin n = 2; st = 1; end
         default: begin n = 4; st = 1; end
      endcase
      m_n  = n;
      last = {32'h0, a} + longint'(n) - 1;
      m_err = (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0) || (last >= MEMB);
      exp_beats.delete();
      if (m_err) begin
         if (!st) m_rdata = 32'h0;
         return;
      end
      v = 0;
      for (int i = 0; i < n; i++) begin
         bt.a  = a + 32'(i);
         bt.we = st;
         if (st) begin
            bt.d = 8'((w >> (8 * (n - 1 - i))) & 32'hFF);
            ref_mem[bt.a[10:0]] = bt.d;
         end else begin
            bt.d = 8'h00;
            v = v * 256 + longint'(ref_mem[bt.a[10:0]]);
         end
         exp_beats.push_back(bt);
      end
      if (!st) begin
         sv = longint'(v);
         if (sg && v >= (64'd1 << (8 * n - 1))) sv = sv - (longint'(1) << (8 * n));
         m_rdata = 32'(sv);
      end
   endfunction

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
   endtask

   task automatic do_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         output int lat, output logic e, output logic [31:0] rd);
      int b0, s0, t0, x0;
      model(o, a, w);
      @(negedge clk);
      op = o; addr = a; wdata = w; req = 1'b1;
      b0 = beat_log.size(); s0 = stall_total; t0 = strobe_total; x0 = both_total;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         req = 1'b0;
      end while (!done && lat < 100);
      e = err; rd = rdata;
      check("done_seen", done, 1);
      check("err", err, m_err);
      check("rdata", rdata, m_rdata);
      check("latency", lat, m_err ? 1 : m_n + 1 + (stall_total - s0));
      check("strobe_cycles", strobe_total - t0, m_err ? 0 : m_n + (stall_total - s0));
      check("both_strobes", both_total - x0, 0);
      check("beat_count", beat_log.size() - b0, exp_beats.size());
      for (int i = 0; i < exp_beats.size(); i++) begin
         if (b0 + i < beat_log.size()) begin
            check("beat_addr", beat_log[b0 + i].a, exp_beats[i].a);
            check("beat_we", beat_log[b0 + i].we, exp_beats[i].we);
            if (exp_beats[i].we) check("beat_wdata", beat_log[b0 + i].d, exp_beats[i].d);
         end
      end
      check("finish_bus_idle", {mem_we, mem_re, mem_wdata, 22'h0} | mem_addr, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
   endtask

   vec_t vecs[20];

   initial begin
      int lat, d0, b0;
      logic e;
      logic [31:0] rd;

      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;

      vecs[0]  = '{L_SW,  32'h10,  32'h12345678, 1'b0, 32'h00000000, 5};
      vecs[1]  = '{L_LW,  32'h10,  32'h0,        1'b0, 32'h12345678, 5};
      vecs[2]  = '{L_SB,  32'h13,  32'hFFFFFF80, 1'b0, 32'h12345678, 2};
      vecs[3]  = '{L_LB,  32'h13,  32'h0,        1'b0, 32'hFFFFFF80, 2};
      vecs[4]  = '{L_LBU, 32'h13,  32'h0,        1'b0, 32'h00000080, 2};
      vecs[5]  = '{L_LH,  32'h12,  32'h0,        1'b0, 32'h00005680, 3};
      vecs[6]  = '{L_LH,  32'h11,  32'h0,        1'b1, 32'h00000000, 1};
      vecs[7]  = '{L_LW,  32'h12,  32'h0,        1'b1, 32'h00000000, 1};
      vecs[8]  = '{L_SH,  32'h20,  32'hDEADBEEF, 1'b0, 32'h00000000, 3};
      vecs[9]  = '{L_LH,  32'h20,  32'h0,        1'b0, 32'hFFFFBEEF, 3};
      vecs[10] = '{L_LW,  32'h20,  32'h0,        1'b0, 32'hBEEF0000, 5};
      vecs[11] = '{L_LW,  32'h7FD, 32'h0,        1'b1, 32'h00000000, 1};
      vecs[12] = '{L_SB,  32'h7FE, 32'h000000A5, 1'b0, 32'h00000000, 2};
      vecs[13] = '{L_LB,  32'h7FE, 32'h0,        1'b0, 32'hFFFFFFA5, 2};
      vecs[14] = '{L_SH,  32'h7FE, 32'h00001111, 1'b1, 32'hFFFFFFA5, 1};
      vecs[15] = '{L_LW,  32'h7FC, 32'h0,        1'b1, 32'h00000000, 1};
      vecs[16] = '{L_LHU, 32'h10,  32'h0,        1'b0, 32'h00001234, 3};
      vecs[17] = '{L_LW,  32'h7F8, 32'h0,        1'b0, 32'h00000000, 5};
      vecs[18] = '{L_SW,  32'h13,  32'h55555555, 1'b1, 32'h00000000, 1};
      vecs[19] = '{L_LW,  32'h10,  32'h0,        1'b0, 32'h12345680, 5};

      rst = 1'b1; req = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_we", mem_we, 0);
      check("rst_re", mem_re, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      rst = 1'b0;
      @(negedge clk);

      // ---- vector table, memory always ready ----
      for (int i = 0; i < 20; i++) begin
         do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, e, rd);
         check("vec_err", e, vecs[i].err);
         check("vec_rdata", rd, vecs[i].rdata);
         check("vec_latency", lat, vecs[i].lat);
      end

      // ---- LW with beat 1 stalled two cycles ----
      rdy_mode = 2; stall_at = 32'h11; stall_len = 2;
      @(negedge clk);
      model(L_LW, 32'h10, 32'h0);
      @(negedge clk);
      op = L_LW; addr = 32'h10; wdata = 32'h0; req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         req = 1'b0;
         if (lat == 2 || lat == 3) begin
            check("stall_addr_held", mem_addr, 32'h11);
            check("stall_re_held", mem_re, 1);
         end
      end while (!done && lat < 100);
      check("stall_latency", lat, 7);
      check("stall_rdata", rdata, m_rdata);
      @(negedge clk);
      rdy_mode = 0;

      // ---- req held high across a whole LW ----
      model(L_LW, 32'h10, 32'h0);
      @(negedge clk);
      op = L_LW; addr = 32'h10; wdata = 32'h0; req = 1'b1;
      b0 = beat_log.size(); d0 = done_cnt;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 100);
      check("hold_latency", lat, 5);
      check("hold_rdata", rdata, m_rdata);
      @(negedge clk);
      check("hold_finish_ignored", busy, 0);
      check("hold_one_done", done_cnt - d0, 1);
      check("hold_beats", beat_log.size() - b0, 4);
      @(negedge clk);
      check("hold_accept_first_idle", busy, 1);
      req = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 100);
      check("hold_second_done", done, 1);
      check("hold_second_rdata", rdata, m_rdata);
      @(negedge clk);

      // ---- reset during beat 2 of SW ----
      @(negedge clk);
      op = L_SW; addr = 32'h40; wdata = 32'hCAFEF00D; req = 1'b1;
      d0 = done_cnt;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mid_we_before", mem_we, 1);
      check("rst_mid_addr_before", mem_addr, 32'h42);
      check("rst_mid_wdata_before", mem_wdata, 32'hF0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_we_async", mem_we, 0);
      check("rst_mid_busy_async", busy, 0);
      check("rst_mid_addr_async", mem_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_no_done", done_cnt - d0, 0);
      check("rst_mid_idle", busy, 0);
      ref_mem[11'h40] = 8'hCA;
      ref_mem[11'h41] = 8'hFE;
      m_rdata = 32'h0;
      do_txn(L_LW, 32'h10, 32'h0, lat, e, rd);
      check("post_rst_lw_latency", lat, 5);
      do_txn(L_LW, 32'h40, 32'h0, lat, e, rd);

      // ---- randomized traffic with random memory stalls ----
      rdy_mode = 1;
      for (int i = 0; i < 60; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra;
         int          r;
         ro = 3'($urandom_range(0, 7));
         r  = $urandom_range(0, 9);
         if (r < 8)       ra = 32'($urandom_range(0, 63));
         else if (r == 8) ra = 32'h7F0 + 32'($urandom_range(0, 15));
         else             ra = $urandom;
         do_txn(ro, ra, $urandom, lat, e, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
